// File: rtl/bomb_pkg.sv
// Shared definitions for the bomb fuse controller: slot state encoding,
// position and counter widths, and the 3x3 blast-radius test used by the
// optional BOMB_CHAIN_EN chain-reaction logic.
package bomb_pkg;

  localparam int POS_W = 6;
  localparam int CNT_W = 28;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ARMED    = 2'd1,
    ST_EXPLODE  = 2'd2,
    ST_COOLDOWN = 2'd3
  } slot_state_t;

  // True when two grid cells are within one step on both axes.
  // The distance is unsigned, so cells do not wrap between 0 and 63.
  function automatic logic in_blast(input logic [POS_W-1:0] ax,
                                    input logic [POS_W-1:0] ay,
                                    input logic [POS_W-1:0] bx,
                                    input logic [POS_W-1:0] by);
    logic [POS_W-1:0] dx;
    logic [POS_W-1:0] dy;
    dx = (ax >= bx) ? (ax - bx) : (bx - ax);
    dy = (ay >= by) ? (ay - by) : (by - ay);
    return (dx <= POS_W'(1)) && (dy <= POS_W'(1));
  endfunction

endpackage

// File: rtl/bomb_slot.sv
// One bomb slot: IDLE -> ARMED (fuse) -> EXPLODE (one cycle) -> COOLDOWN
// (re-arm lockout) -> IDLE. Position is latched on an accepted place and held
// until the next accepted place. i_chain forces an ARMED bomb to detonate on
// the next cycle; the top ties it low unless BOMB_CHAIN_EN is defined.
//
// Handshake: i_place is a level request, sampled every rising edge; it is
// accepted only while the slot is IDLE and is otherwise dropped, never queued.
module bomb_slot
  import bomb_pkg::*;
#(
  parameter int N            = 50000000,
  parameter int FUSE_SEC     = 3,
  parameter int COOLDOWN_SEC = 2
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             i_place,
  input  logic [POS_W-1:0] i_pos_x,
  input  logic [POS_W-1:0] i_pos_y,
  input  logic             i_chain,
  output logic [POS_W-1:0] o_bomb_x,
  output logic [POS_W-1:0] o_bomb_y,
  output logic             o_armed,
  output logic             o_explode,
  output slot_state_t      o_state
);

  localparam longint FUSE_CYC  = longint'(N) * longint'(FUSE_SEC);
  localparam longint COOL_CYC  = longint'(N) * longint'(COOLDOWN_SEC);
  localparam longint CNT_LIMIT = longint'(1) << CNT_W;

  localparam logic [CNT_W-1:0] FUSE_LOAD = CNT_W'(FUSE_CYC - 1);
  localparam logic [CNT_W-1:0] COOL_LOAD = (COOL_CYC > 0) ? CNT_W'(COOL_CYC - 1) : '0;

  // Refuse to build with a zero fuse or with durations the counter cannot hold.
  generate
    if (N <= 0 || FUSE_SEC <= 0 || COOLDOWN_SEC < 0 ||
        FUSE_CYC >= CNT_LIMIT || COOL_CYC >= CNT_LIMIT) begin : g_bad_params
      $error("bomb_slot: illegal N/FUSE_SEC/COOLDOWN_SEC combination");
    end
  endgenerate

  slot_state_t       r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [POS_W-1:0]  r_bomb_x;
  logic [POS_W-1:0]  r_bomb_y;
  logic              r_armed;
  logic              r_explode;

  // Slot FSM with fuse/cooldown counter and registered status outputs.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_bomb_x  <= '0;
      r_bomb_y  <= '0;
      r_armed   <= 1'b0;
      r_explode <= 1'b0;
    end else begin
      r_explode <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (i_place) begin
            r_bomb_x <= i_pos_x;
            r_bomb_y <= i_pos_y;
            r_cnt    <= FUSE_LOAD;
            r_armed  <= 1'b1;
            r_state  <= ST_ARMED;
          end
        end
        ST_ARMED: begin
          if (r_cnt == '0 || i_chain) begin
            r_cnt     <= '0;
            r_armed   <= 1'b0;
            r_explode <= 1'b1;
            r_state   <= ST_EXPLODE;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        ST_EXPLODE: begin
          if (COOL_CYC == 0) begin
            r_state <= ST_IDLE;
          end else begin
            r_cnt   <= COOL_LOAD;
            r_state <= ST_COOLDOWN;
          end
        end
        ST_COOLDOWN: begin
          if (r_cnt == '0) begin
            r_state <= ST_IDLE;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        default: begin
          r_cnt     <= '0;
          r_armed   <= 1'b0;
          r_state   <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_bomb_x  = r_bomb_x;
  assign o_bomb_y  = r_bomb_y;
  assign o_armed   = r_armed;
  assign o_explode = r_explode;
  assign o_state   = r_state;

endmodule

// File: rtl/bomb_fuse_controller.sv
// Two independent bomb slots (red, blue) plus the shared detonation pulse
// that feeds the stun stage. Defining BOMB_CHAIN_EN adds chain reactions: an
// armed bomb inside the 3x3 blast of the other slot's exploding bomb
// detonates on the next cycle. dbgRedState/dbgBlueState expose slot states.
module bomb_fuse_controller
  import bomb_pkg::*;
#(
  parameter int N            = 50000000,
  parameter int FUSE_SEC     = 3,
  parameter int COOLDOWN_SEC = 2
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             redPlace,
  input  logic             bluePlace,
  input  logic [POS_W-1:0] redPosX,
  input  logic [POS_W-1:0] redPosY,
  input  logic [POS_W-1:0] bluePosX,
  input  logic [POS_W-1:0] bluePosY,
  output logic [POS_W-1:0] RbombPosX,
  output logic [POS_W-1:0] RbombPosY,
  output logic [POS_W-1:0] BbombPosX,
  output logic [POS_W-1:0] BbombPosY,
  output logic             redBombArmed,
  output logic             blueBombArmed,
  output logic             redExplode,
  output logic             blueExplode,
  output logic             bombExploded,
  output slot_state_t      dbgRedState,
  output slot_state_t      dbgBlueState
);

  logic w_red_chain;
  logic w_blue_chain;

`ifdef BOMB_CHAIN_EN
  // A slot is chained when the other slot is exploding next to its bomb.
  assign w_red_chain  = blueExplode && in_blast(RbombPosX, RbombPosY, BbombPosX, BbombPosY);
  assign w_blue_chain = redExplode  && in_blast(RbombPosX, RbombPosY, BbombPosX, BbombPosY);
`else
  // Slots stay fully independent.
  assign w_red_chain  = 1'b0;
  assign w_blue_chain = 1'b0;
`endif

  bomb_slot #(
    .N            (N),
    .FUSE_SEC     (FUSE_SEC),
    .COOLDOWN_SEC (COOLDOWN_SEC)
  ) u_red (
    .clk       (clk),
    .resetn    (resetn),
    .i_place   (redPlace),
    .i_pos_x   (redPosX),
    .i_pos_y   (redPosY),
    .i_chain   (w_red_chain),
    .o_bomb_x  (RbombPosX),
    .o_bomb_y  (RbombPosY),
    .o_armed   (redBombArmed),
    .o_explode (redExplode),
    .o_state   (dbgRedState)
  );

  bomb_slot #(
    .N            (N),
    .FUSE_SEC     (FUSE_SEC),
    .COOLDOWN_SEC (COOLDOWN_SEC)
  ) u_blue (
    .clk       (clk),
    .resetn    (resetn),
    .i_place   (bluePlace),
    .i_pos_x   (bluePosX),
    .i_pos_y   (bluePosY),
    .i_chain   (w_blue_chain),
    .o_bomb_x  (BbombPosX),
    .o_bomb_y  (BbombPosY),
    .o_armed   (blueBombArmed),
    .o_explode (blueExplode),
    .o_state   (dbgBlueState)
  );

  // Either detonation drives the shared stun trigger.
  assign bombExploded = redExplode | blueExplode;

endmodule

// File: tb/tb_bomb_fuse_controller.sv
// Bench for bomb_fuse_controller with N=4, FUSE_SEC=3, COOLDOWN_SEC=2.
// The reference model tracks each slot as "armed at cycle A, explodes at
// cycle X" and derives every output from elapsed cycles. Chain expectations
// follow BOMB_CHAIN_EN when it is defined for the build.
module tb_bomb_fuse_controller;
  import bomb_pkg::*;

  localparam int N            = 4;
  localparam int FUSE_SEC     = 3;
  localparam int COOLDOWN_SEC = 2;
  localparam int FUSE_CYC     = N * FUSE_SEC;
  localparam int COOL_CYC     = N * COOLDOWN_SEC;
`ifdef BOMB_CHAIN_EN
  localparam bit CHAIN = 1'b1;
`else
  localparam bit CHAIN = 1'b0;
`endif

  logic             clk;
  logic             resetn;
  logic             redPlace, bluePlace;
  logic [POS_W-1:0] redPosX, redPosY, bluePosX, bluePosY;
  logic [POS_W-1:0] RbombPosX, RbombPosY, BbombPosX, BbombPosY;
  logic             redBombArmed, blueBombArmed;
  logic             redExplode, blueExplode, bombExploded;
  slot_state_t      dbgRedState, dbgBlueState;

  bomb_fuse_controller #(
    .N            (N),
    .FUSE_SEC     (FUSE_SEC),
    .COOLDOWN_SEC (COOLDOWN_SEC)
  ) dut (
    .clk           (clk),
    .resetn        (resetn),
    .redPlace      (redPlace),
    .bluePlace     (bluePlace),
    .redPosX       (redPosX),
    .redPosY       (redPosY),
    .bluePosX      (bluePosX),
    .bluePosY      (bluePosY),
    .RbombPosX     (RbombPosX),
    .RbombPosY     (RbombPosY),
    .BbombPosX     (BbombPosX),
    .BbombPosY     (BbombPosY),
    .redBombArmed  (redBombArmed),
    .blueBombArmed (blueBombArmed),
    .redExplode    (redExplode),
    .blueExplode   (blueExplode),
    .bombExploded  (bombExploded),
    .dbgRedState   (dbgRedState),
    .dbgBlueState  (dbgBlueState)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- counters ----------------
  int n_cmp = 0;
  int n_mis = 0;
  int cyc   = 0;

  // ---------------- reference model ----------------
  // Slot s: m_act says a bomb was ever accepted since reset, m_arm is the
  // first armed cycle, m_exp the detonation cycle. Index 0 = red, 1 = blue.
  bit               m_act [2];
  int               m_arm [2];
  int               m_exp [2];
  logic [POS_W-1:0] m_bx  [2];
  logic [POS_W-1:0] m_by  [2];

  function automatic bit m_armed(int s, int c);
    return m_act[s] && c >= m_arm[s] && c < m_exp[s];
  endfunction

  function automatic bit m_expl(int s, int c);
    return m_act[s] && c == m_exp[s];
  endfunction

  function automatic bit m_idle(int s, int c);
    return !m_act[s] || c > m_exp[s] + COOL_CYC;
  endfunction

  function automatic slot_state_t m_state(int s, int c);
    if (m_idle(s, c))  return ST_IDLE;
    if (m_armed(s, c)) return ST_ARMED;
    if (m_expl(s, c))  return ST_EXPLODE;
    return ST_COOLDOWN;
  endfunction

  function automatic bit m_near();
    int dx, dy;
    dx = int'(m_bx[0]) - int'(m_bx[1]);
    dy = int'(m_by[0]) - int'(m_by[1]);
    return (dx >= -1 && dx <= 1 && dy >= -1 && dy <= 1);
  endfunction

  task automatic model_reset();
    for (int s = 0; s < 2; s++) begin
      m_act[s] = 1'b0;
      m_arm[s] = 0;
      m_exp[s] = 0;
      m_bx[s]  = '0;
      m_by[s]  = '0;
    end
  endtask

  // Advance the model across the rising edge that starts cycle cyc.
  task automatic model_edge();
    bit               pl [2];
    bit               arm_p [2];
    bit               exp_p [2];
    bit               idl_p [2];
    bit               near_p;
    logic [POS_W-1:0] px [2];
    logic [POS_W-1:0] py [2];
    int c;
    if (!resetn) return;
    c = cyc;
    pl[0] = redPlace;  px[0] = redPosX;  py[0] = redPosY;
    pl[1] = bluePlace; px[1] = bluePosX; py[1] = bluePosY;
    for (int s = 0; s < 2; s++) begin
      arm_p[s] = m_armed(s, c - 1);
      exp_p[s] = m_expl(s, c - 1);
      idl_p[s] = m_idle(s, c - 1);
    end
    near_p = m_near();
    for (int s = 0; s < 2; s++) begin
      if (idl_p[s] && pl[s]) begin
        m_act[s] = 1'b1;
        m_arm[s] = c;
        m_exp[s] = c + FUSE_CYC;
        m_bx[s]  = px[s];
        m_by[s]  = py[s];
      end else if (CHAIN && arm_p[s] && exp_p[1-s] && near_p) begin
        m_exp[s] = c;
      end
    end
  endtask

  // ---------------- scoreboard ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s cycle=%0d observed=%0d expected=%0d", tag, cyc, obs, exp);
    end
  endtask

  task automatic check_all();
    int c;
    c = cyc;
    check("red_pos_x",   32'(RbombPosX),     32'(m_bx[0]));
    check("red_pos_y",   32'(RbombPosY),     32'(m_by[0]));
    check("blue_pos_x",  32'(BbombPosX),     32'(m_bx[1]));
    check("blue_pos_y",  32'(BbombPosY),     32'(m_by[1]));
    check("red_armed",   32'(redBombArmed),  32'(m_armed(0, c)));
    check("blue_armed",  32'(blueBombArmed), 32'(m_armed(1, c)));
    check("red_explode", 32'(redExplode),    32'(m_expl(0, c)));
    check("blue_explode",32'(blueExplode),   32'(m_expl(1, c)));
    check("bomb_exploded", 32'(bombExploded), 32'(m_expl(0, c) | m_expl(1, c)));
    check("red_state",   32'(dbgRedState),   32'(m_state(0, c)));
    check("blue_state",  32'(dbgBlueState),  32'(m_state(1, c)));
  endtask

  // ---------------- driver ----------------
  // One clock: model follows the edge, outputs are checked 1 time unit later.
  task automatic step();
    @(posedge clk);
    cyc++;
    model_edge();
    #1;
    check_all();
  endtask

  // Assert reset mid-cycle and verify the outputs clear without a clock edge.
  task automatic async_reset(input int hold_cycles);
    #2;
    resetn = 1'b0;
    #1;
    model_reset();
    check_all();
    repeat (hold_cycles) step();
    resetn = 1'b1;
  endtask

  // Watchdog in case the stimulus ever stalls.
  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  int n_arm, n_expl, n_boom, n_cool, t_arm1, t_arm2, t_red, t_blue, t_boom;
  logic prev_armed;

  initial begin
    // ---------- reset state ----------
    resetn = 1'b0;
    redPlace = 1'b0; bluePlace = 1'b0;
    redPosX = '0; redPosY = '0; bluePosX = '0; bluePosY = '0;
    model_reset();
    #1;
    check_all();
    repeat (3) step();

    // ---------- single red bomb, placed on the first edge out of reset ----------
    resetn = 1'b1;
    redPlace = 1'b1; redPosX = 6'd10; redPosY = 6'd20;
    n_arm = 0; n_expl = 0; n_boom = 0; n_cool = 0;
    step();
    redPlace = 1'b0; redPosX = 6'd33; redPosY = 6'd44;
    if (redBombArmed) n_arm++;
    for (int i = 0; i < 29; i++) begin
      step();
      if (redBombArmed) n_arm++;
      if (redExplode) n_expl++;
      if (bombExploded) n_boom++;
      if (dbgRedState == ST_COOLDOWN) n_cool++;
    end
    check("t1_pos_x", 32'(RbombPosX), 32'd10);
    check("t1_pos_y", 32'(RbombPosY), 32'd20);
    check("t1_armed_cycles", 32'(n_arm), 32'd12);
    check("t1_explode_cycles", 32'(n_expl), 32'd1);
    check("t1_boom_cycles", 32'(n_boom), 32'd1);
    check("t1_cooldown_cycles", 32'(n_cool), 32'd8);
    check("t1_idle_after", 32'(dbgRedState), 32'(ST_IDLE));

    // ---------- place held high while the player moves ----------
    redPlace = 1'b1; redPosX = 6'd5; redPosY = 6'd5;
    step();
    t_arm1 = cyc; t_arm2 = -1;
    prev_armed = redBombArmed;
    for (int i = 0; i < 30; i++) begin
      redPosX = 6'($urandom_range(6, 63));
      redPosY = 6'($urandom_range(6, 63));
      step();
      if (redBombArmed && !prev_armed && t_arm2 < 0) t_arm2 = cyc;
      prev_armed = redBombArmed;
    end
    // Accepted in the first IDLE cycle (21 after the first arm), so the
    // second Armed shows one cycle after that.
    check("t2_rearm_distance", 32'(t_arm2 - t_arm1), 32'd22);
    redPlace = 1'b0;
    repeat (25) step();

    // ---------- both players drop on the same cycle ----------
    redPlace = 1'b1;  redPosX = 6'd40;  redPosY = 6'd40;
    bluePlace = 1'b1; bluePosX = 6'd10; bluePosY = 6'd10;
    step();
    redPlace = 1'b0; bluePlace = 1'b0;
    t_red = -1; t_blue = -1; t_boom = -1; n_boom = 0;
    for (int i = 0; i < 24; i++) begin
      step();
      if (redExplode) t_red = cyc;
      if (blueExplode) t_blue = cyc;
      if (bombExploded) begin t_boom = cyc; n_boom++; end
    end
    check("t3_red_vs_blue", 32'(t_red), 32'(t_blue));
    check("t3_boom_vs_red", 32'(t_boom), 32'(t_red));
    check("t3_boom_cycles", 32'(n_boom), 32'd1);

    // ---------- reset in the middle of the fuse ----------
    redPlace = 1'b1; redPosX = 6'd7; redPosY = 6'd8;
    step();
    redPlace = 1'b0;
    repeat (5) step();
    async_reset(2);
    check("t4_armed_cleared", 32'(redBombArmed), 32'd0);
    check("t4_pos_cleared", 32'(RbombPosX), 32'd0);
    n_expl = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (redExplode || bombExploded) n_expl++;
    end
    check("t4_no_explode_after_reset", 32'(n_expl), 32'd0);

    // ---------- chain reaction: adjacent, then out of range ----------
    for (int k = 0; k < 2; k++) begin
      redPlace = 1'b1; redPosX = 6'd0; redPosY = 6'd0;
      step();
      redPlace = 1'b0;
      repeat (4) step();
      bluePlace = 1'b1;
      bluePosX = (k == 0) ? 6'd1 : 6'd2;
      bluePosY = (k == 0) ? 6'd1 : 6'd0;
      step();
      bluePlace = 1'b0;
      t_red = -1; t_blue = -1;
      for (int i = 0; i < 40; i++) begin
        step();
        if (redExplode) t_red = cyc;
        if (blueExplode) t_blue = cyc;
      end
      if (k == 0)
        check("t5_chain_adjacent", 32'(t_blue - t_red), (CHAIN ? 32'd1 : 32'd5));
      else
        check("t5_chain_far", 32'(t_blue - t_red), 32'd5);
    end

    // ---------- randomized traffic ----------
    for (int i = 0; i < 1500; i++) begin
      redPlace  = ($urandom_range(0, 7) == 0);
      bluePlace = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 3) == 0) begin
        redPosX  = 6'($urandom_range(0, 63)); redPosY  = 6'($urandom_range(0, 63));
        bluePosX = 6'($urandom_range(0, 63)); bluePosY = 6'($urandom_range(0, 63));
      end else begin
        redPosX  = 6'($urandom_range(0, 3));  redPosY  = 6'($urandom_range(0, 3));
        bluePosX = 6'($urandom_range(0, 3));  bluePosY = 6'($urandom_range(0, 3));
      end
      step();
      if ($urandom_range(0, 399) == 0) async_reset(2);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
